// File: rtl/omem_drain.sv
// omem_drain: reads result rows back from output memory O after a MAC run and
// streams their DW-bit elements over valid/ready through a 2-word prefetch buffer.
module omem_drain #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int AW    = 4
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                START,
  input  logic [11:0]         MNT,
  output logic                BUSY,
  output logic                DONE,
  output logic                EN_O,
  output logic                RW_O,
  output logic [AW-1:0]       ADDR_O,
  input  logic [LANES*DW-1:0] RDATA_O,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [DW-1:0]       OUT_DATA,
  output logic                OUT_EOR,
  output logic                OUT_LAST
);

  localparam int WW = LANES * DW;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NW = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      m_q, m_d;
  logic [NW-1:0]   nc_q, nc_d;
  logic [3:0]      issued_q, issued_d;
  logic [3:0]      row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [1:0]      occ_q, occ_d;
  logic [WW-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
  logic            en_q, en_d, infl_q;
  logic            busy_q, busy_d, done_q, done_d;
  logic            valid_q, valid_d, eor_q, eor_d, last_q, last_d;
  logic [DW-1:0]   data_q, data_d;

  logic            accept_s, empty_s, xfer_s, pop_s, cap_s;
  logic [NW-1:0]   nc_s;
  logic            mnt_unused_s;

  function automatic logic [DW-1:0] lane_sel(input logic [WW-1:0] word, input logic [CW-1:0] col);
    lane_sel = word[int'(col)*DW +: DW];
  endfunction

  assign accept_s     = START && (state_q != RUN);
  assign empty_s      = (MNT[11:8] == 4'd0) || (MNT[7:4] == 4'd0);
  assign nc_s         = (MNT[7:4] > 4'(LANES)) ? NW'(LANES) : NW'(MNT[7:4]);
  assign xfer_s       = valid_q && OUT_READY;
  assign pop_s        = xfer_s && eor_q;
  // A read issued last cycle returns its data this cycle.
  assign cap_s        = infl_q;
  assign mnt_unused_s = ^MNT[3:0];

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a START in the DONE cycle is accepted like in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          if (empty_s) state_d = FIN;
          else         state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (xfer_s && last_q) state_d = FIN;
        else                  state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters and prefetch buffer next state.
  always_comb begin
    m_d      = m_q;
    nc_d     = nc_q;
    issued_d = issued_q;
    occ_d    = occ_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    col_d    = col_q;
    row_d    = row_q;
    if (accept_s) begin
      m_d      = MNT[11:8];
      nc_d     = nc_s;
      issued_d = 4'd0;
      occ_d    = 2'd0;
      col_d    = CW'(0);
      row_d    = 4'd0;
    end else begin
      if (en_q) issued_d = issued_q + 4'd1;
      else      issued_d = issued_q;
      case ({pop_s, cap_s})
        2'b11: begin
          if (occ_q == 2'd2) begin
            buf0_d = buf1_q;
            buf1_d = RDATA_O;
          end else begin
            buf0_d = RDATA_O;
          end
        end
        2'b10: begin
          buf0_d = buf1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd0) buf0_d = RDATA_O;
          else               buf1_d = RDATA_O;
          occ_d = occ_q + 2'd1;
        end
        default: begin
          occ_d = occ_q;
        end
      endcase
      if (xfer_s) col_d = eor_q ? CW'(0) : col_q + CW'(1);
      else        col_d = col_q;
      if (pop_s) row_d = row_q + 4'd1;
      else       row_d = row_q;
    end
  end

  // FSM outputs, computed from next state so every port comes straight from a flop.
  always_comb begin
    if ((state_d == RUN) && (issued_d < m_d) && ((occ_d + {1'b0, en_q}) < 2'd2)) en_d = 1'b1;
    else                                                                        en_d = 1'b0;
    busy_d  = (state_d == RUN);
    done_d  = (state_d == FIN);
    valid_d = (occ_d != 2'd0);
    if (valid_d) begin
      data_d = lane_sel(buf0_d, col_d);
      eor_d  = (NW'(col_d) == (nc_d - NW'(1)));
      last_d = eor_d && (row_d == (m_d - 4'd1));
    end else begin
      data_d = {DW{1'b0}};
      eor_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_q      <= 4'd0;
      nc_q     <= {NW{1'b0}};
      issued_q <= 4'd0;
      row_q    <= 4'd0;
      col_q    <= {CW{1'b0}};
      occ_q    <= 2'd0;
      buf0_q   <= {WW{1'b0}};
      buf1_q   <= {WW{1'b0}};
      en_q     <= 1'b0;
      infl_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= {DW{1'b0}};
      eor_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      m_q      <= m_d;
      nc_q     <= nc_d;
      issued_q <= issued_d;
      row_q    <= row_d;
      col_q    <= col_d;
      occ_q    <= occ_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      en_q     <= en_d;
      infl_q   <= en_q;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      eor_q    <= eor_d;
      last_q   <= last_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign EN_O      = en_q;
  assign RW_O      = 1'b0;
  assign ADDR_O    = AW'(issued_q);
  assign OUT_VALID = valid_q;
  assign OUT_DATA  = data_q;
  assign OUT_EOR   = eor_q;
  assign OUT_LAST  = last_q;

endmodule

// File: tb/tb_omem_drain.sv
// Directed bench for omem_drain: synchronous O-memory model, negedge monitor,
// immediate-assertion checks against hand-derived element sequences.
module tb_omem_drain;

  logic        CLK = 1'b0;
  logic        RSTN, START, OUT_READY;
  logic [11:0] MNT;
  logic        BUSY, DONE, EN_O, RW_O, OUT_VALID, OUT_EOR, OUT_LAST;
  logic [3:0]  ADDR_O;
  logic [63:0] rdata;
  logic [15:0] OUT_DATA;

  omem_drain #(.DW(16), .LANES(4), .AW(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .MNT(MNT), .BUSY(BUSY), .DONE(DONE),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .RDATA_O(rdata),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_EOR(OUT_EOR), .OUT_LAST(OUT_LAST)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int k;
  logic [63:0] mem [16];

  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) if (EN_O) rdata <= mem[ADDR_O];

  // monitor state, cleared through clr
  logic        clr = 1'b1;
  int          n_en, n_x, n_pop, n_done, n_valid, first_en, first_v, first_x, last_x, done_cyc, max_out, stall_bad;
  logic        have_stall;
  logic [15:0] s_data;
  logic        s_eor, s_last;
  logic [15:0] xd [64];
  logic        xe [64];
  logic        xl [64];
  logic [3:0]  addr_log [16];

  always @(negedge CLK) begin
    if (clr) begin
      n_en <= 0; n_x <= 0; n_pop <= 0; n_done <= 0; n_valid <= 0;
      first_en <= -1; first_v <= -1; first_x <= -1; last_x <= -1; done_cyc <= -1;
      max_out <= 0; stall_bad <= 0; have_stall <= 1'b0;
    end else begin
      if (have_stall && (!OUT_VALID || OUT_DATA !== s_data || OUT_EOR !== s_eor || OUT_LAST !== s_last))
        stall_bad <= stall_bad + 1;
      have_stall <= OUT_VALID && !OUT_READY;
      s_data <= OUT_DATA; s_eor <= OUT_EOR; s_last <= OUT_LAST;
      if (EN_O) begin
        if (n_en < 16) addr_log[n_en] <= ADDR_O;
        if (first_en < 0) first_en <= cyc;
        n_en <= n_en + 1;
      end
      if ((n_en + int'(EN_O) - n_pop) > max_out) max_out <= n_en + int'(EN_O) - n_pop;
      if (OUT_VALID) begin
        n_valid <= n_valid + 1;
        if (first_v < 0) first_v <= cyc;
      end
      if (OUT_VALID && OUT_READY) begin
        if (n_x < 64) begin
          xd[n_x] <= OUT_DATA; xe[n_x] <= OUT_EOR; xl[n_x] <= OUT_LAST;
        end
        if (first_x < 0) first_x <= cyc;
        last_x <= cyc;
        n_x <= n_x + 1;
        if (OUT_EOR) n_pop <= n_pop + 1;
      end
      if (DONE) begin
        n_done <= n_done + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // clears the monitor, then pulses START; k = edge count at the sampling edge
  task automatic start_run(input logic [3:0] m, input logic [3:0] n, output int kk);
    clr = 1'b1;
    @(negedge CLK); #1;
    clr = 1'b0;
    MNT = {m, n, 4'h0};
    START = 1'b1;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    kk = cyc;
    START = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating. mid_at >= 0 pulses a stray START.
  task automatic drive(input int mode, input int mid_at);
    for (int i = 0; i < 400; i++) begin
      if (n_done != 0) break;
      @(posedge CLK); #1;
      OUT_READY = (mode == 0) || (i % 4 == 0) || (i % 4 == 3);
      START = (i == mid_at);
      if (i == mid_at) MNT = 12'h210;
    end
    START = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_drain(input string tag, input int m, input int nc);
    logic [17:0] ev;
    chk({tag, "/count"}, n_x, m * nc);
    for (int i = 0; i < n_x && i < 64; i++) begin
      ev = {(i % nc == nc - 1) ? 1'b1 : 1'b0, (i == m * nc - 1) ? 1'b1 : 1'b0, 16'((i / nc) * 4 + i % nc)};
      chk($sformatf("%s/elem%0d{eor,last,data}", tag, i), {xe[i], xl[i], xd[i]}, ev);
    end
    chk({tag, "/issues"}, n_en, m);
    for (int j = 0; j < n_en && j < 16; j++) chk($sformatf("%s/addr%0d", tag, j), addr_log[j], j);
    chk({tag, "/done_count"}, n_done, 1);
    chk({tag, "/done_after_last"}, done_cyc, last_x + 1);
    chk({tag, "/max_outstanding_le2"}, (max_out <= 2) ? 1 : 0, 1);
    chk({tag, "/stall_stable"}, stall_bad, 0);
  endtask

  initial begin
    RSTN = 1'b0; START = 1'b0; MNT = 12'h000; OUT_READY = 1'b0;
    for (int r = 0; r < 16; r++)
      mem[r] = {16'(4 * r + 3), 16'(4 * r + 2), 16'(4 * r + 1), 16'(4 * r)};
    #12;
    chk("reset_outputs", {BUSY, DONE, EN_O, RW_O, ADDR_O, OUT_VALID, OUT_DATA, OUT_EOR, OUT_LAST}, 0);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);

    // M=4,N=4, no backpressure
    start_run(4'd4, 4'd4, k);
    chk("A/busy_k1", BUSY, 1);
    chk("A/en_addr_k1", {EN_O, ADDR_O}, 5'b1_0000);
    drive(0, -1);
    check_drain("A", 4, 4);
    chk("A/first_en_ofs", first_en - k, 0);
    chk("A/first_valid_ofs", first_v - k, 2);
    chk("A/no_gaps", last_x - first_x, 15);

    // same run with ready 1,0,0,1
    start_run(4'd4, 4'd4, k);
    drive(1, -1);
    check_drain("B", 4, 4);

    // M=3,N=2
    start_run(4'd3, 4'd2, k);
    drive(0, -1);
    check_drain("C", 3, 2);

    // N=7 clamps to 4 columns
    start_run(4'd1, 4'd7, k);
    drive(0, -1);
    check_drain("D", 1, 4);

    // M=0
    start_run(4'd0, 4'd4, k);
    chk("E/done_busy_k1", {DONE, BUSY}, 2'b10);
    drive(0, -1);
    chk("E/done_count", n_done, 1);
    chk("E/done_cyc", done_cyc - k, 0);
    chk("E/no_en", n_en, 0);
    chk("E/no_valid", n_valid, 0);

    // N=0
    start_run(4'd3, 4'd0, k);
    drive(0, -1);
    chk("F/done_count", n_done, 1);
    chk("F/done_cyc", done_cyc - k, 0);
    chk("F/no_en", n_en, 0);
    chk("F/no_valid", n_valid, 0);

    // stray START with different MNT during the run
    start_run(4'd4, 4'd4, k);
    drive(1, 3);
    check_drain("G", 4, 4);

    // reset after 5 transfers
    start_run(4'd4, 4'd4, k);
    for (int i = 0; i < 50; i++) begin
      if (n_x >= 5) break;
      @(negedge CLK);
    end
    @(posedge CLK); #2;
    RSTN = 1'b0;
    #1;
    chk("H/reset_outputs", {BUSY, DONE, EN_O, RW_O, ADDR_O, OUT_VALID, OUT_DATA, OUT_EOR, OUT_LAST}, 0);
    chk("H/fifth_elem", xd[4], 4);
    repeat (3) @(negedge CLK);
    chk("H/no_done", n_done, 0);
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("H/idle_after_reset", {BUSY, EN_O, OUT_VALID}, 0);
    start_run(4'd2, 4'd4, k);
    drive(0, -1);
    check_drain("H", 2, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
